// File: rtl/vc_pkg.sv
// Shared types and constants for the VC FIFO reader: FSM states, source ids
// and the destination-select bit position.
package vc_pkg;

    localparam int DATA_WIDTH = 6;
    localparam int DEST_BIT   = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2,
        ERROR  = 2'd3
    } vc_state_e;

    typedef enum logic {
        SRC_VC0 = 1'b0,
        SRC_VC1 = 1'b1
    } vc_src_e;

    // Destination bit for an arbitrary word width (DEST_BIT covers the default).
    function automatic int dest_bit(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/vc_route_stage.sv
// Stage-2 register of the VC reader: picks the word from the in-flight source
// and steers it to D0 or D1 by its MSB.
module vc_route_stage
    import vc_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inflight_valid,
    input  vc_src_e               inflight_src,
    input  logic [data_width-1:0] vc0_data_in,
    input  logic [data_width-1:0] vc1_data_in,
    output logic [data_width-1:0] d_data_out,
    output logic                  d0_push,
    output logic                  d1_push
);

    localparam int MSB = dest_bit(data_width);

    logic [data_width-1:0] word;
    logic [data_width-1:0] d_data_d, d_data_q;
    logic                  d0_push_d, d0_push_q;
    logic                  d1_push_d, d1_push_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        word      = (inflight_src == SRC_VC1) ? vc1_data_in : vc0_data_in;
        d_data_d  = '0;
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;
        if (inflight_valid) begin
            d_data_d  = word;
            d0_push_d = ~word[MSB];
            d1_push_d = word[MSB];
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_data_q  <= '0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
        end else begin
            d_data_q  <= d_data_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
        end
    end

    assign d_data_out = d_data_q;
    assign d0_push    = d0_push_q;
    assign d1_push    = d1_push_q;

endmodule

// File: rtl/vc_fifo_reader.sv
// Drains VC0/VC1 FIFOs (strict VC0 priority) into destination FIFOs D0/D1.
// Optional per-source delivered-word counters under VC_READER_STATS_EN.
module vc_fifo_reader
    import vc_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] vc0_data_in,
    input  logic [data_width-1:0] vc1_data_in,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic                  vc0_error,
    input  logic                  vc1_error,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    input  logic                  d0_full,
    input  logic                  d1_full,
    output logic                  vc0_rd_enable,
    output logic                  vc1_rd_enable,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [data_width-1:0] d_data_out,
    output logic [1:0]            state_o,
    output logic                  error_o
`ifdef VC_READER_STATS_EN
    ,
    output logic [15:0]           vc0_word_cnt,
    output logic [15:0]           vc1_word_cnt
`endif
);

    vc_state_e state_d, state_q;
    logic      error_d, error_q;
    logic      inflight_valid_d, inflight_valid_q;
    vc_src_e   inflight_src_d, inflight_src_q;
    logic      bp, any_ne, pop_ok, push_into_full;

    always_comb begin
        bp             = d0_almost_full | d0_full | d1_almost_full | d1_full;
        any_ne         = ~vc0_empty | ~vc1_empty;
        pop_ok         = (state_q != ERROR) & ~bp;
        vc0_rd_enable  = pop_ok & ~vc0_empty;
        vc1_rd_enable  = pop_ok & vc0_empty & ~vc1_empty;
        push_into_full = (d0_push & d0_full) | (d1_push & d1_full);

        if ((state_q == ERROR) | vc0_error | vc1_error | push_into_full)
            state_d = ERROR;
        else if (bp & any_ne)
            state_d = STALL;
        else if (any_ne)
            state_d = ACTIVE;
        else
            state_d = IDLE;

        error_d          = (state_d == ERROR);
        inflight_valid_d = vc0_rd_enable | vc1_rd_enable;
        inflight_src_d   = vc1_rd_enable ? SRC_VC1 : SRC_VC0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            error_q          <= 1'b0;
            inflight_valid_q <= 1'b0;
            inflight_src_q   <= SRC_VC0;
        end else begin
            state_q          <= state_d;
            error_q          <= error_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_src_q   <= inflight_src_d;
        end
    end

    assign state_o = state_q;
    assign error_o = error_q;

    // The FIFO presents the popped word one cycle after the strobe, so the
    // in-flight record lines up with the data bus for the route stage.
    vc_route_stage #(
        .data_width(data_width)
    ) u_route (
        .clk            (clk),
        .reset          (reset),
        .inflight_valid (inflight_valid_q),
        .inflight_src   (inflight_src_q),
        .vc0_data_in    (vc0_data_in),
        .vc1_data_in    (vc1_data_in),
        .d_data_out     (d_data_out),
        .d0_push        (d0_push),
        .d1_push        (d1_push)
    );

`ifdef VC_READER_STATS_EN
    logic [15:0] vc0_cnt_d, vc0_cnt_q;
    logic [15:0] vc1_cnt_d, vc1_cnt_q;

    // Counts advance on the same edge that registers the push.
    always_comb begin
        vc0_cnt_d = vc0_cnt_q;
        vc1_cnt_d = vc1_cnt_q;
        if (inflight_valid_q && inflight_src_q == SRC_VC0 && vc0_cnt_q != 16'hFFFF)
            vc0_cnt_d = vc0_cnt_q + 16'd1;
        if (inflight_valid_q && inflight_src_q == SRC_VC1 && vc1_cnt_q != 16'hFFFF)
            vc1_cnt_d = vc1_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc0_cnt_q <= '0;
            vc1_cnt_q <= '0;
        end else begin
            vc0_cnt_q <= vc0_cnt_d;
            vc1_cnt_q <= vc1_cnt_d;
        end
    end

    assign vc0_word_cnt = vc0_cnt_q;
    assign vc1_word_cnt = vc1_cnt_q;
`endif

endmodule

// File: tb/tb_vc_fifo_reader.sv
// Directed bench for vc_fifo_reader: table of pop-strobe vectors plus
// hand-written multi-cycle sequences with bench-side FIFO models.
module tb_vc_fifo_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] vc0_data_in, vc1_data_in;
    logic       vc0_empty, vc1_empty, vc0_error, vc1_error;
    logic       d0_almost_full, d1_almost_full, d0_full, d1_full;
    logic       vc0_rd_enable, vc1_rd_enable, d0_push, d1_push;
    logic [5:0] d_data_out;
    logic [1:0] state_o;
    logic       error_o;
`ifdef VC_READER_STATS_EN
    logic [15:0] vc0_word_cnt, vc1_word_cnt;
`endif

    always #5 clk = ~clk;

    vc_fifo_reader dut (
        .clk            (clk),
        .reset          (reset),
        .vc0_data_in    (vc0_data_in),
        .vc1_data_in    (vc1_data_in),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .vc0_error      (vc0_error),
        .vc1_error      (vc1_error),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .d0_full        (d0_full),
        .d1_full        (d1_full),
        .vc0_rd_enable  (vc0_rd_enable),
        .vc1_rd_enable  (vc1_rd_enable),
        .d0_push        (d0_push),
        .d1_push        (d1_push),
        .d_data_out     (d_data_out),
        .state_o        (state_o),
        .error_o        (error_o)
`ifdef VC_READER_STATS_EN
        ,
        .vc0_word_cnt   (vc0_word_cnt),
        .vc1_word_cnt   (vc1_word_cnt)
`endif
    );

    typedef struct packed {
        logic       dest;
        logic [5:0] data;
    } push_t;

    typedef struct packed {
        logic e0, e1, d0af, d0f, d1af, d1f;
        logic rd0, rd1;
    } vec_t;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    push_t      rx[$];
    push_t      exp_rx[$];
    int total = 0, bad = 0;
    int cyc = 0, rd0_cnt, rd1_cnt, both_rd, bad_idle, first_rd, first_push;
    logic rd0_s, rd1_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample DUT at negedge, then advance the FIFO models after the edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        rd0_s = vc0_rd_enable;
        rd1_s = vc1_rd_enable;
        if (rd0_s) rd0_cnt++;
        if (rd1_s) rd1_cnt++;
        if (rd0_s && rd1_s) both_rd++;
        if ((rd0_s || rd1_s) && first_rd < 0) first_rd = cyc;
        if (d0_push && d1_push) bad_idle++;
        if (d0_push || d1_push) begin
            rx.push_back({d1_push, d_data_out});
            if (first_push < 0) first_push = cyc;
        end else if (d_data_out != 6'h00) begin
            bad_idle++;
        end
        @(posedge clk);
        #1;
        vc0_data_in = '0;
        vc1_data_in = '0;
        if (rd0_s && q0.size() > 0) vc0_data_in = q0.pop_front();
        if (rd1_s && q1.size() > 0) vc1_data_in = q1.pop_front();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
    endtask

    task automatic clear_stats();
        rx.delete();
        exp_rx.delete();
        rd0_cnt = 0; rd1_cnt = 0; both_rd = 0; bad_idle = 0;
        first_rd = -1; first_push = -1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q0.delete(); q1.delete();
        vc0_data_in = '0; vc1_data_in = '0;
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        vc0_error = 1'b0; vc1_error = 1'b0;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        d0_full = 1'b0; d1_full = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        clear_stats();
    endtask

    task automatic load(input logic [5:0] w0[$], input logic [5:0] w1[$]);
        q0 = w0;
        q1 = w1;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
    endtask

    task automatic compare_rx(input string name);
        check({name, " count"}, rx.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx.size(); i++)
            check(name, 32'(rx[i]), 32'(exp_rx[i]));
    endtask

    vec_t vecs[9];

    initial begin
        clear_stats();
        reset = 1'b0;
        vc0_data_in = '0; vc1_data_in = '0;
        vc0_error = 1'b0; vc1_error = 1'b0;
        vecs[0] = '{e0:0, e1:1, d0af:0, d0f:0, d1af:0, d1f:0, rd0:1, rd1:0};
        vecs[1] = '{e0:1, e1:0, d0af:0, d0f:0, d1af:0, d1f:0, rd0:0, rd1:1};
        vecs[2] = '{e0:0, e1:0, d0af:0, d0f:0, d1af:0, d1f:0, rd0:1, rd1:0};
        vecs[3] = '{e0:1, e1:1, d0af:0, d0f:0, d1af:0, d1f:0, rd0:0, rd1:0};
        vecs[4] = '{e0:0, e1:0, d0af:1, d0f:0, d1af:0, d1f:0, rd0:0, rd1:0};
        vecs[5] = '{e0:0, e1:0, d0af:0, d0f:1, d1af:0, d1f:0, rd0:0, rd1:0};
        vecs[6] = '{e0:0, e1:1, d0af:0, d0f:0, d1af:1, d1f:0, rd0:0, rd1:0};
        vecs[7] = '{e0:1, e1:0, d0af:0, d0f:0, d1af:0, d1f:1, rd0:0, rd1:0};
        vecs[8] = '{e0:1, e1:0, d0af:1, d0f:0, d1af:0, d1f:0, rd0:0, rd1:0};

        // Reset values, then pop-strobe table (state held at IDLE by reset).
        #2;
        check("rst d0_push", d0_push, 0);
        check("rst d1_push", d1_push, 0);
        check("rst d_data_out", d_data_out, 0);
        check("rst state", state_o, 0);
        check("rst error", error_o, 0);
        foreach (vecs[i]) begin
            {vc0_empty, vc1_empty} = {vecs[i].e0, vecs[i].e1};
            {d0_almost_full, d0_full} = {vecs[i].d0af, vecs[i].d0f};
            {d1_almost_full, d1_full} = {vecs[i].d1af, vecs[i].d1f};
            #1;
            check($sformatf("vec%0d rd0", i), vc0_rd_enable, vecs[i].rd0);
            check($sformatf("vec%0d rd1", i), vc1_rd_enable, vecs[i].rd1);
        end

        // 1: three VC0 words, routed by MSB, two-cycle latency.
        do_reset();
        load('{6'h05, 6'h21, 6'h0A}, '{});
        repeat (8) tick();
        check("t1 rd0 cycles", rd0_cnt, 3);
        check("t1 rd1 cycles", rd1_cnt, 0);
        check("t1 latency", first_push - first_rd, 2);
        exp_rx = '{'{1'b0, 6'h05}, '{1'b1, 6'h21}, '{1'b0, 6'h0A}};
        compare_rx("t1 pushes");
        check("t1 state idle", state_o, 0);
        check("t1 error", error_o, 0);
        check("t1 idle data zero", bad_idle, 0);

        // 2: VC0 strictly before VC1.
        do_reset();
        load('{6'h03, 6'h24}, '{6'h11, 6'h2A});
        repeat (10) tick();
        exp_rx = '{'{1'b0, 6'h03}, '{1'b1, 6'h24}, '{1'b0, 6'h11}, '{1'b1, 6'h2A}};
        compare_rx("t2 pushes");
        check("t2 both rd", both_rd, 0);
        check("t2 rd1 cycles", rd1_cnt, 2);

        // 3: backpressure mid-burst; in-flight words drain, nothing dropped.
        do_reset();
        load('{6'h01, 6'h22, 6'h03, 6'h24, 6'h05, 6'h26}, '{});
        repeat (2) tick();
        d1_almost_full = 1'b1;
        repeat (5) tick();
        check("t3 no pops in bp", rd0_cnt, 2);
        check("t3 state stall", state_o, 2);
        check("t3 at most 2 in flight", rx.size() <= 2, 1);
        d1_almost_full = 1'b0;
        tick();
        check("t3 resume", rd0_cnt, 3);
        repeat (10) tick();
        exp_rx = '{'{1'b0, 6'h01}, '{1'b1, 6'h22}, '{1'b0, 6'h03},
                   '{1'b1, 6'h24}, '{1'b0, 6'h05}, '{1'b1, 6'h26}};
        compare_rx("t3 pushes");

        // 4: one-cycle vc1_error; sticky ERROR, in-flight words still delivered.
        do_reset();
        load('{6'h07, 6'h08, 6'h09, 6'h0B}, '{});
        tick();
        vc1_error = 1'b1;
        tick();
        vc1_error = 1'b0;
        repeat (6) tick();
        check("t4 state error", state_o, 3);
        check("t4 error sticky", error_o, 1);
        check("t4 pops stop", rd0_cnt, 2);
        exp_rx = '{'{1'b0, 6'h07}, '{1'b0, 6'h08}};
        compare_rx("t4 pushes");

        // 4b: push into a full destination sets ERROR, word still presented.
        do_reset();
        load('{6'h0C}, '{});
        tick();
        d0_full = 1'b1;
        repeat (3) tick();
        d0_full = 1'b0;
        tick();
        check("t4b state error", state_o, 3);
        check("t4b error", error_o, 1);
        exp_rx = '{'{1'b0, 6'h0C}};
        compare_rx("t4b pushes");

        // 5: async reset between pop and push discards the in-flight word.
        do_reset();
        load('{6'h15, 6'h16}, '{});
        repeat (2) tick();
        check("t5 push before reset", {d0_push, d_data_out}, {1'b1, 6'h15});
        rx.delete();
        reset = 1'b0;
        #1;
        check("t5 d0_push", d0_push, 0);
        check("t5 d1_push", d1_push, 0);
        check("t5 data", d_data_out, 0);
        check("t5 state", state_o, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();
        check("t5 no late push", rx.size(), 0);

`ifdef VC_READER_STATS_EN
        // 6: per-source delivered-word counters.
        do_reset();
        load('{6'h01, 6'h02, 6'h23, 6'h04, 6'h25}, '{6'h31, 6'h12});
        repeat (15) tick();
        check("t6 vc0 count", vc0_word_cnt, 5);
        check("t6 vc1 count", vc1_word_cnt, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
